// File: rtl/mcb_pkg.sv
// -----------------------------------------------------------------------------
// mcb_pkg
// Shared definitions for the MCB frame writer and frame reader controllers:
// MCB command opcodes, the depth of the MCB data FIFOs, and the controller
// state encodings.
// -----------------------------------------------------------------------------
package mcb_pkg;

  localparam logic [2:0] MCB_CMD_WRITE  = 3'b000;
  localparam logic [2:0] MCB_CMD_READ   = 3'b001;
  localparam int         MCB_FIFO_DEPTH = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/mcb_burst_credit.sv
// -----------------------------------------------------------------------------
// mcb_burst_credit
// Tracks words requested from (issued) and consumed out of (popped) an MCB data
// FIFO. It computes the length of the next burst and whether that burst fits
// in the FIFO without overflowing it. The same unit can throttle either the
// read side or the write side of a port.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero both counters (start of a frame)
//   issue        a burst of 'len' words is issued this cycle
//   pop          one word leaves the FIFO this cycle
//   issued       words requested so far in this frame
//   len          length of the next burst, min(BURST_LEN, words remaining)
//   permit       the next burst fits: outstanding + len <= FIFO_DEPTH
//   all_issued   every word of the frame has been requested
//   all_popped   every word of the frame has been consumed
// -----------------------------------------------------------------------------
module mcb_burst_credit
  import mcb_pkg::*;
#(
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 32,
  parameter int FIFO_DEPTH  = MCB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        issue,
  input  logic        pop,
  output logic [19:0] issued,
  output logic [6:0]  len,
  output logic        permit,
  output logic        all_issued,
  output logic        all_popped
);

  localparam logic [19:0] FW    = 20'(FRAME_WORDS);
  localparam logic [19:0] BL    = 20'(BURST_LEN);
  localparam logic [20:0] DEPTH = 21'(FIFO_DEPTH);

  logic [19:0] popped;
  logic [19:0] remaining;
  logic [19:0] outstanding;

  assign remaining   = FW - issued;
  assign outstanding = issued - popped;
  // The final burst is short when FRAME_WORDS is not a multiple of BURST_LEN.
  assign len         = (remaining < BL) ? remaining[6:0] : 7'(BURST_LEN);
  assign all_issued  = (issued == FW);
  assign all_popped  = (popped == FW);
  // Credits count words requested but not yet popped, so data already in
  // flight inside the MCB is covered as well as data sitting in the FIFO.
  assign permit      = !all_issued &&
                       (({1'b0, outstanding} + {14'd0, len}) <= DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued <= '0;
      popped <= '0;
    end else if (clear) begin
      issued <= '0;
      popped <= '0;
    end else begin
      if (issue) issued <= issued + {13'd0, len};
      if (pop)   popped <= popped + 20'd1;
    end
  end

endmodule

// File: rtl/mcb_frame_reader.sv
// -----------------------------------------------------------------------------
// mcb_frame_reader
// Fetches one stored frame from DDR2 through an MCB read port, using
// credit-limited bursts, and streams the pixels to the HDMI colour path over
// a valid/ready handshake. The frame buffer is chosen from the writer's
// frame-select output when start_frame is accepted.
//
// Ports:
//   clk, SYS_RESETn              colour clock, async active-low reset
//   mem_calib_done               MCB calibrated; start_frame is ignored until set
//   start_frame, frame_select    begin a frame fetch from buffer 0/1
//   cmd_en/instr/bl/byte_addr    MCB read command; cmd_full is backpressure
//   rd_en, rd_data, rd_empty     MCB read FIFO (first-word fall-through)
//   pix_valid/ready/data         pixel stream, {R,G,B}
//   busy                         a frame fetch is in progress
//   frame_done                   pulse after the last pixel is accepted
//   underrun                     sticky; consumer was ready while no pixel was held
// -----------------------------------------------------------------------------
module mcb_frame_reader
  import mcb_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR0  = 30'h0000000,
  parameter logic [29:0] BASE_ADDR1  = 30'h0400000,
  parameter int          FRAME_WORDS = 307200,
  parameter int          BURST_LEN   = 32,
  parameter int          FIFO_DEPTH  = MCB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        SYS_RESETn,
  input  logic        mem_calib_done,
  input  logic        start_frame,
  input  logic        frame_select,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  logic [1:0]  state;
  logic [29:0] base;
  logic [19:0] issued;
  logic [6:0]  len;
  logic        permit;
  logic        all_issued;
  logic        all_popped;
  logic        start_ok;
  logic        issue_go;
  logic        busy_w;
  logic        rd_data_unused;

  assign rd_data_unused = ^rd_data[31:24];

  assign cmd_instr = MCB_CMD_READ;
  assign busy_w    = (state != ST_IDLE);
  assign busy      = busy_w;
  assign start_ok  = (state == ST_IDLE) && start_frame && mem_calib_done;
  // cmd_en low last cycle guarantees single-cycle strobes with a gap between
  // them, so the MCB never sees two back-to-back commands from this port.
  assign issue_go  = (state == ST_FETCH) && !cmd_full && !cmd_en && permit;
  // Gated by busy so a stale MCB FIFO is never popped while idle.
  assign rd_en     = busy_w && !rd_empty && (!pix_valid || pix_ready) &&
                     !all_popped;

  mcb_burst_credit #(
    .FRAME_WORDS (FRAME_WORDS),
    .BURST_LEN   (BURST_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_credit (
    .clk        (clk),
    .rst_n      (SYS_RESETn),
    .clear      (start_ok),
    .issue      (issue_go),
    .pop        (rd_en),
    .issued     (issued),
    .len        (len),
    .permit     (permit),
    .all_issued (all_issued),
    .all_popped (all_popped)
  );

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      state         <= ST_IDLE;
      base          <= '0;
      cmd_en        <= 1'b0;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      cmd_en     <= issue_go;
      frame_done <= 1'b0;

      if (issue_go) begin
        cmd_bl        <= 6'(len - 7'd1);
        cmd_byte_addr <= base + {8'd0, issued, 2'b00};
      end

      // A refill on the same cycle as an accept replaces the pixel with no bubble.
      if (rd_en) begin
        pix_valid <= 1'b1;
        pix_data  <= rd_data[23:0];
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end

      if (pix_ready && !pix_valid && busy_w && !all_popped) underrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            base     <= frame_select ? BASE_ADDR1 : BASE_ADDR0;
            underrun <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (all_issued) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (all_popped && !pix_valid) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_mcb_frame_reader
// Two readers (96-word and 70-word frames) against a behavioural MCB read
// port whose data word equals byte address / 4.
// -----------------------------------------------------------------------------
module tb_mcb_frame_reader;
  import mcb_pkg::*;

  localparam logic [29:0] BASE1 = 30'h0400000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        SYS_RESETn;
  logic        mem_calib_done;
  logic        start_frame   [2];
  logic        frame_select  [2];
  logic        cmd_full      [2];
  logic        pix_ready     [2];
  logic        cmd_en        [2];
  logic [2:0]  cmd_instr     [2];
  logic [5:0]  cmd_bl        [2];
  logic [29:0] cmd_byte_addr [2];
  logic        rd_en         [2];
  logic [31:0] rd_data       [2];
  logic        rd_empty      [2];
  logic        pix_valid     [2];
  logic [23:0] pix_data      [2];
  logic        busy          [2];
  logic        frame_done    [2];
  logic        underrun      [2];

  mcb_frame_reader #(.FRAME_WORDS(96), .BURST_LEN(32), .FIFO_DEPTH(64)) u_dut0 (
    .clk(clk), .SYS_RESETn(SYS_RESETn), .mem_calib_done(mem_calib_done),
    .start_frame(start_frame[0]), .frame_select(frame_select[0]),
    .cmd_en(cmd_en[0]), .cmd_instr(cmd_instr[0]), .cmd_bl(cmd_bl[0]),
    .cmd_byte_addr(cmd_byte_addr[0]), .cmd_full(cmd_full[0]),
    .rd_en(rd_en[0]), .rd_data(rd_data[0]), .rd_empty(rd_empty[0]),
    .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .pix_data(pix_data[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .underrun(underrun[0]));

  mcb_frame_reader #(.FRAME_WORDS(70), .BURST_LEN(32), .FIFO_DEPTH(64)) u_dut1 (
    .clk(clk), .SYS_RESETn(SYS_RESETn), .mem_calib_done(mem_calib_done),
    .start_frame(start_frame[1]), .frame_select(frame_select[1]),
    .cmd_en(cmd_en[1]), .cmd_instr(cmd_instr[1]), .cmd_bl(cmd_bl[1]),
    .cmd_byte_addr(cmd_byte_addr[1]), .cmd_full(cmd_full[1]),
    .rd_en(rd_en[1]), .rd_data(rd_data[1]), .rd_empty(rd_empty[1]),
    .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .pix_data(pix_data[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .underrun(underrun[1]));

  // ---------------- MCB read-port model and observers ----------------
  logic [31:0] fmem [2][128];
  int          wp [2], rp [2], vis [2];
  bit          ovf [2];
  int          n_cmd [2], n_pix [2], n_done [2], bad_pix [2];
  logic [29:0] log_addr [2][8];
  logic [5:0]  log_bl   [2][8];
  int          exp_pix_base [2];
  logic        log_clr;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_data[k]  = fmem[k][rp[k] % 128];
      rd_empty[k] = (rp[k] == vis[k]);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!SYS_RESETn) begin
        wp[k]  <= 0;
        rp[k]  <= 0;
        vis[k] <= 0;
      end else begin
        if (cmd_en[k]) begin
          for (int i = 0; i <= int'(cmd_bl[k]); i++)
            fmem[k][(wp[k] + i) % 128] <= 32'(cmd_byte_addr[k] / 4) + 32'(i);
          wp[k] <= wp[k] + int'(cmd_bl[k]) + 1;
        end
        if (vis[k] < wp[k]) vis[k] <= vis[k] + 1;
        if (rd_en[k]) rp[k] <= rp[k] + 1;
      end
      if (log_clr) begin
        n_cmd[k]   <= 0;
        n_pix[k]   <= 0;
        n_done[k]  <= 0;
        bad_pix[k] <= 0;
        ovf[k]     <= 1'b0;
      end else begin
        if (wp[k] - rp[k] > 64) ovf[k] <= 1'b1;
        if (cmd_en[k]) begin
          log_addr[k][n_cmd[k] % 8] <= cmd_byte_addr[k];
          log_bl[k][n_cmd[k] % 8]   <= cmd_bl[k];
          n_cmd[k] <= n_cmd[k] + 1;
        end
        if (pix_valid[k] && pix_ready[k]) begin
          if (pix_data[k] != 24'(exp_pix_base[k] + n_pix[k])) bad_pix[k] <= bad_pix[k] + 1;
          n_pix[k] <= n_pix[k] + 1;
        end
        if (frame_done[k]) n_done[k] <= n_done[k] + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  bit started [2];
  bit ph [2];

  // mode 0: ready low; 1: ready high once a pixel appears;
  // 2: ready toggles once a pixel appears; 3: ready always high
  task automatic tick(input int k, input int mode);
    @(negedge clk);
    if (pix_valid[k]) started[k] = 1'b1;
    ph[k] = ~ph[k];
    case (mode)
      0:       pix_ready[k] = 1'b0;
      1:       pix_ready[k] = started[k];
      2:       pix_ready[k] = started[k] & ph[k];
      default: pix_ready[k] = 1'b1;
    endcase
  endtask

  task automatic pulse_start(input int k, input bit fsel, input bit clr);
    @(negedge clk);
    frame_select[k] = fsel;
    start_frame[k]  = 1'b1;
    log_clr         = clr;
    started[k]      = 1'b0;
    if (clr) exp_pix_base[k] = int'((fsel ? BASE1 : 30'h0) >> 2);
    @(negedge clk);
    start_frame[k] = 1'b0;
    log_clr        = 1'b0;
  endtask

  task automatic wait_done(input int k, input int mode, input int budget);
    int c;
    c = 0;
    while (n_done[k] == 0 && c < budget) begin
      tick(k, mode);
      c++;
    end
    check("frame_done_seen", 64'(n_done[k] > 0), 64'd1);
    repeat (4) tick(k, mode);
    check("frame_done_once", 64'(n_done[k]), 64'd1);
    check("busy_after_frame", 64'(busy[k]), 64'd0);
    pix_ready[k] = 1'b0;
  endtask

  typedef struct {
    int          inst;
    bit          fsel;
    int          mode;
    int          ncmd;
    logic [5:0]  bl2;
    logic [29:0] base;
    int          npix;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int   k;
    int   c;

    vecs[0] = '{0, 1'b0, 1, 3, 6'd31, 30'h0, 96};
    vecs[1] = '{1, 1'b0, 1, 3, 6'd5,  30'h0, 70};
    vecs[2] = '{0, 1'b0, 2, 3, 6'd31, 30'h0, 96};
    vecs[3] = '{0, 1'b1, 1, 3, 6'd31, BASE1, 96};
    vecs[4] = '{1, 1'b1, 2, 3, 6'd5,  BASE1, 70};

    SYS_RESETn     = 1'b0;
    mem_calib_done = 1'b1;
    log_clr        = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_frame[i]  = 1'b0;
      frame_select[i] = 1'b0;
      cmd_full[i]     = 1'b0;
      pix_ready[i]    = 1'b0;
      exp_pix_base[i] = 0;
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check("reset_ctrl", 64'({cmd_en[i], rd_en[i], pix_valid[i], busy[i],
                               frame_done[i], underrun[i]}), 64'd0);
      check("reset_cmd_fields", 64'({cmd_bl[i], cmd_byte_addr[i]}), 64'd0);
      check("reset_cmd_instr", 64'(cmd_instr[i]), 64'(3'b001));
    end
    SYS_RESETn = 1'b1;
    log_clr    = 1'b0;
    @(negedge clk);

    // Whole frames from the vector table
    for (int v = 0; v < 5; v++) begin
      k = vecs[v].inst;
      pulse_start(k, vecs[v].fsel, 1'b1);
      wait_done(k, vecs[v].mode, 2000);
      check("n_cmd", 64'(n_cmd[k]), 64'(vecs[v].ncmd));
      for (int i = 0; i < 3; i++) begin
        check("cmd_addr", 64'(log_addr[k][i]), 64'(vecs[v].base + 30'(128 * i)));
        check("cmd_bl", 64'(log_bl[k][i]), (i == 2) ? 64'(vecs[v].bl2) : 64'd31);
      end
      check("n_pix", 64'(n_pix[k]), 64'(vecs[v].npix));
      check("pix_order_errors", 64'(bad_pix[k]), 64'd0);
      check("fifo_overflow", 64'(ovf[k]), 64'd0);
      if (vecs[v].mode == 2) check("underrun_backpressure", 64'(underrun[k]), 64'd0);
    end

    // Credit limit: consumer stalled, only 64 words may be requested
    pulse_start(0, 1'b0, 1'b1);
    repeat (60) tick(0, 0);
    check("credit_two_cmds", 64'(n_cmd[0]), 64'd2);
    check("credit_pix_held", 64'(pix_valid[0]), 64'd1);
    wait_done(0, 1, 2000);
    check("credit_n_cmd", 64'(n_cmd[0]), 64'd3);
    check("credit_n_pix", 64'(n_pix[0]), 64'd96);
    check("credit_pix_order", 64'(bad_pix[0]), 64'd0);

    // Command FIFO full holds off command issue
    cmd_full[0] = 1'b1;
    pulse_start(0, 1'b0, 1'b1);
    repeat (10) tick(0, 1);
    check("cmdfull_no_cmd", 64'(n_cmd[0]), 64'd0);
    check("cmdfull_busy", 64'(busy[0]), 64'd1);
    cmd_full[0] = 1'b0;
    wait_done(0, 1, 2000);
    check("cmdfull_n_pix", 64'(n_pix[0]), 64'd96);

    // Start guard while uncalibrated, buffer 1, ignored mid-frame start
    mem_calib_done = 1'b0;
    pulse_start(0, 1'b1, 1'b1);
    repeat (10) tick(0, 1);
    check("uncal_no_cmd", 64'(n_cmd[0]), 64'd0);
    check("uncal_not_busy", 64'(busy[0]), 64'd0);
    mem_calib_done = 1'b1;
    pulse_start(0, 1'b1, 1'b1);
    repeat (10) tick(0, 1);
    check("buf1_first_addr", 64'(log_addr[0][0]), 64'(BASE1));
    pulse_start(0, 1'b0, 1'b0);
    wait_done(0, 1, 2000);
    check("midstart_n_cmd", 64'(n_cmd[0]), 64'd3);
    check("midstart_last_addr", 64'(log_addr[0][2]), 64'(BASE1 + 30'd256));
    check("midstart_n_pix", 64'(n_pix[0]), 64'd96);
    check("midstart_pix_order", 64'(bad_pix[0]), 64'd0);

    // Asynchronous reset mid-frame, then a clean restart
    pulse_start(0, 1'b0, 1'b1);
    c = 0;
    while (n_pix[0] < 40 && c < 500) begin
      tick(0, 3);
      c++;
    end
    check("reached_40_pixels", 64'(n_pix[0] >= 40), 64'd1);
    #2 SYS_RESETn = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({cmd_en[0], rd_en[0], pix_valid[0], busy[0],
                                 frame_done[0], underrun[0]}), 64'd0);
    check("async_rst_cmd_fields", 64'({cmd_bl[0], cmd_byte_addr[0]}), 64'd0);
    check("async_rst_pix_data", 64'(pix_data[0]), 64'd0);
    pix_ready[0] = 1'b0;
    repeat (2) @(negedge clk);
    SYS_RESETn = 1'b1;
    pulse_start(0, 1'b0, 1'b1);
    wait_done(0, 1, 2000);
    check("restart_first_addr", 64'(log_addr[0][0]), 64'd0);
    check("restart_n_cmd", 64'(n_cmd[0]), 64'd3);
    check("restart_n_pix", 64'(n_pix[0]), 64'd96);
    check("restart_pix_order", 64'(bad_pix[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
